// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types, constants and polarity helpers for the seven-segment scanner
//   state_t        : scan FSM state encoding (ST_BLANK, ST_SHOW)
//   PWM_W          : width of the brightness PWM counter
//   seg_pol/dig_pol: map "1 = lit" patterns onto pin polarity
//   seg_off/dig_off: all-inactive pin values for a given polarity
package seg_scan_pkg;
   typedef enum logic {ST_BLANK, ST_SHOW} state_t;
   localparam int PWM_W = 4;
   function automatic logic [7:0] seg_pol(input logic [7:0] lit, input bit act);
      return act ? lit : ~lit;
   endfunction
   function automatic logic [3:0] dig_pol(input logic [3:0] lit, input bit act);
      return act ? lit : ~lit;
   endfunction
   function automatic logic [7:0] seg_off(input bit act);
      return seg_pol(8'h00, act);
   endfunction
   function automatic logic [3:0] dig_off(input bit act);
      return dig_pol(4'h0, act);
   endfunction
endpackage

// File: rtl/seg_pwm.sv
// seg_pwm: brightness PWM counter, counts microsecond ticks and reports "on" while cnt < bright
//   sys_clk_p : clock
//   sys_rst   : synchronous active-high reset
//   clr       : restart the PWM period at 0
//   inc       : advance the counter (wraps 15 -> 0)
//   bright    : duty setting, on for bright of every 16 counts
//   cnt       : current PWM count
//   on        : high while cnt < bright
import seg_scan_pkg::*;
module seg_pwm (
   input  logic             sys_clk_p,
   input  logic             sys_rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [PWM_W-1:0] bright,
   output logic [PWM_W-1:0] cnt,
   output logic             on
);
   always_ff @(posedge sys_clk_p)
      if (sys_rst || clr) cnt <= '0;
      else if (inc) cnt <= cnt + 1'b1;
   assign on = cnt < bright;
endmodule

// File: rtl/seg_scan.sv
// seg_scan: multiplexed seven-segment driver with per-slot blanking gap and brightness PWM
//   sys_clk_p, sys_rst        : clock, synchronous active-high reset
//   ena_us, ena_ms            : one-cycle microsecond / millisecond strobes
//   seg_hex0..seg_hex3        : digit segment patterns, bit7 = dp, 1 = lit
//   dig_ena                   : per-digit display enable mask
//   bright                    : brightness 0..15 (duty bright/16)
//   seg_out, dig_out          : registered board pins, polarity SEG_ACT / DIG_ACT
//   scan_idx                  : digit currently owning the scan slot
import seg_scan_pkg::*;
module seg_scan #(
   parameter int NDIG     = 4,
   parameter bit SEG_ACT  = 1'b0,
   parameter bit DIG_ACT  = 1'b0,
   parameter int BLANK_US = 8
) (
   input  logic       sys_clk_p,
   input  logic       sys_rst,
   input  logic       ena_us,
   input  logic       ena_ms,
   input  logic [7:0] seg_hex0,
   input  logic [7:0] seg_hex1,
   input  logic [7:0] seg_hex2,
   input  logic [7:0] seg_hex3,
   input  logic [3:0] dig_ena,
   input  logic [3:0] bright,
   output logic [7:0] seg_out,
   output logic [3:0] dig_out,
   output logic [1:0] scan_idx
);
   localparam logic [7:0] SEG_OFF   = seg_off(SEG_ACT);
   localparam logic [3:0] DIG_OFF   = dig_off(DIG_ACT);
   localparam logic [9:0] BLANK_END = 10'(BLANK_US);
   localparam logic [1:0] IDX_LAST  = 2'(NDIG - 1);
   state_t           state, state_n;
   logic [9:0]       blank_cnt, blank_n;
   logic [7:0]       seg_lat, lat_n, seg_sel;
   logic [1:0]       idx_n;
   logic             pwm_clr, pwm_inc, pwm_on, lit;
   logic [PWM_W-1:0] pwm_cnt;
   assign seg_sel = scan_idx == 2'd0 ? seg_hex0 :
                    scan_idx == 2'd1 ? seg_hex1 :
                    scan_idx == 2'd2 ? seg_hex2 : seg_hex3;
   // ena_ms ends the slot from either state and swallows a coincident ena_us
   always_comb begin
      state_n = state;
      idx_n   = scan_idx;
      blank_n = blank_cnt;
      lat_n   = seg_lat;
      pwm_clr = 1'b0;
      if (ena_ms) begin
         idx_n   = scan_idx == IDX_LAST ? 2'd0 : scan_idx + 2'd1;
         state_n = ST_BLANK;
         blank_n = '0;
      end else if (ena_us && state == ST_BLANK) begin
         blank_n = blank_cnt + 10'd1;
         if (blank_n == BLANK_END) begin
            lat_n   = seg_sel;
            pwm_clr = 1'b1;
            state_n = ST_SHOW;
         end
      end
   end
   assign pwm_inc = ena_us && !ena_ms && state == ST_SHOW;
   seg_pwm u_pwm (
      .sys_clk_p (sys_clk_p),
      .sys_rst   (sys_rst),
      .clr       (pwm_clr),
      .inc       (pwm_inc),
      .bright    (bright),
      .cnt       (pwm_cnt),
      .on        (pwm_on)
   );
   assign lit = state == ST_SHOW && dig_ena[scan_idx] && pwm_on;
   always_ff @(posedge sys_clk_p)
      if (sys_rst) begin
         state     <= ST_BLANK;
         scan_idx  <= '0;
         blank_cnt <= '0;
         seg_lat   <= '0;
         seg_out   <= SEG_OFF;
         dig_out   <= DIG_OFF;
      end else begin
         state     <= state_n;
         scan_idx  <= idx_n;
         blank_cnt <= blank_n;
         seg_lat   <= lat_n;
         seg_out   <= lit ? seg_pol(seg_lat, SEG_ACT) : SEG_OFF;
         dig_out   <= lit ? dig_pol(4'b0001 << scan_idx, DIG_ACT) : DIG_OFF;
      end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan using a slot/microsecond-count model
module tb_seg_scan;
   localparam int BLANK_US = 8;
   logic       sys_clk_p = 1'b0, sys_rst = 1'b1, ena_us = 1'b0, ena_ms = 1'b0;
   logic [7:0] hex [4];
   logic [3:0] dig_ena = 4'hF, bright = 4'd15;
   logic [7:0] seg_out;
   logic [3:0] dig_out;
   logic [1:0] scan_idx;
   int checks = 0, errors = 0;
   seg_scan #(.NDIG(4), .SEG_ACT(1'b0), .DIG_ACT(1'b0), .BLANK_US(BLANK_US)) dut (
      .sys_clk_p (sys_clk_p),
      .sys_rst   (sys_rst),
      .ena_us    (ena_us),
      .ena_ms    (ena_ms),
      .seg_hex0  (hex[0]),
      .seg_hex1  (hex[1]),
      .seg_hex2  (hex[2]),
      .seg_hex3  (hex[3]),
      .dig_ena   (dig_ena),
      .bright    (bright),
      .seg_out   (seg_out),
      .dig_out   (dig_out),
      .scan_idx  (scan_idx)
   );
   always #5 sys_clk_p = ~sys_clk_p;
   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask
   // Model: a slot is defined by its digit index and the number of counted microseconds
   // since the slot began; the digit shows once BLANK_US have elapsed, with PWM phase
   // being the microseconds elapsed since then modulo 16. Pins lag the model by one cycle.
   int         m_idx = 0, m_us = 0;
   logic [7:0] m_snap = 8'h00, exp_seg;
   logic [3:0] exp_dig;
   logic [1:0] exp_idx;
   bit         m_ok = 0, m_lit;
   always @(posedge sys_clk_p) begin
      if (sys_rst) begin
         exp_seg = 8'hFF;
         exp_dig = 4'hF;
         m_idx   = 0;
         m_us    = 0;
         m_ok    = 1;
      end else if (m_ok) begin
         m_lit   = m_us >= BLANK_US && dig_ena[m_idx] && ((m_us - BLANK_US) % 16) < int'(bright);
         exp_seg = m_lit ? ~m_snap : 8'hFF;
         exp_dig = m_lit ? ~(4'b0001 << m_idx) : 4'hF;
         if (ena_ms) begin
            m_idx = (m_idx + 1) % 4;
            m_us  = 0;
         end else if (ena_us) begin
            m_us++;
            if (m_us == BLANK_US) m_snap = hex[m_idx];
         end
      end
      exp_idx = 2'(m_idx);
   end
   always @(negedge sys_clk_p)
      if (m_ok) begin
         chk("model_seg", seg_out, exp_seg);
         chk("model_dig", {4'h0, dig_out}, {4'h0, exp_dig});
         chk("model_idx", {6'h0, scan_idx}, {6'h0, exp_idx});
         if (dig_out == 4'hF) chk("inv_dark_seg", seg_out, 8'hFF);
         chk("inv_onehot", {7'h0, $countones(~dig_out) <= 1}, 8'h01);
      end
   task automatic cyc(input logic us, input logic ms);
      ena_us = us;
      ena_ms = ms;
      @(negedge sys_clk_p);
      ena_us = 1'b0;
      ena_ms = 1'b0;
   endtask
   task automatic us_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
   endtask
   logic [3:0] dig_tab [5] = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD};
   logic [1:0] idx_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
   initial begin
      hex = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
      repeat (3) @(negedge sys_clk_p);
      sys_rst = 1'b0;
      chk("rst_seg", seg_out, 8'hFF);
      chk("rst_dig", {4'h0, dig_out}, 8'h0F);
      chk("rst_idx", {6'h0, scan_idx}, 8'h00);
      repeat (5) cyc(1'b0, 1'b0);
      chk("idle_dig", {4'h0, dig_out}, 8'h0F);
      chk("idle_idx", {6'h0, scan_idx}, 8'h00);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b1);
         chk("scan_idx", {6'h0, scan_idx}, {6'h0, idx_tab[k]});
         us_n(7);
         chk("blank7_dig", {4'h0, dig_out}, 8'h0F);
         us_n(1);
         chk("blank8_dig", {4'h0, dig_out}, 8'h0F);
         cyc(1'b0, 1'b0);
         chk("show_dig", {4'h0, dig_out}, {4'h0, dig_tab[k]});
         chk("show_seg", seg_out, ~hex[idx_tab[k]]);
      end
      bright = 4'd4;
      us_n(3);
      cyc(1'b0, 1'b0);
      chk("pwm3_dig", {4'h0, dig_out}, 8'h0D);
      us_n(1);
      cyc(1'b0, 1'b0);
      chk("pwm4_dig", {4'h0, dig_out}, 8'h0F);
      chk("pwm4_seg", seg_out, 8'hFF);
      us_n(12);
      cyc(1'b0, 1'b0);
      chk("pwm_wrap_dig", {4'h0, dig_out}, 8'h0D);
      bright = 4'd0;
      us_n(3);
      cyc(1'b0, 1'b0);
      chk("bright0_dig", {4'h0, dig_out}, 8'h0F);
      bright = 4'd15;
      us_n(2);
      hex[1] = 8'h7F;
      us_n(2);
      cyc(1'b0, 1'b0);
      chk("snap_hold_seg", seg_out, 8'hF9);
      dig_ena = 4'b1011;
      cyc(1'b0, 1'b1);
      us_n(8);
      cyc(1'b0, 1'b0);
      chk("mask_dig", {4'h0, dig_out}, 8'h0F);
      us_n(20);
      chk("mask_late_dig", {4'h0, dig_out}, 8'h0F);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      chk("back_to_1", {6'h0, scan_idx}, 8'h01);
      us_n(8);
      cyc(1'b0, 1'b0);
      chk("snap_new_seg", seg_out, 8'h80);
      chk("snap_new_dig", {4'h0, dig_out}, 8'h0D);
      dig_ena = 4'hF;
      cyc(1'b0, 1'b1);
      us_n(7);
      cyc(1'b1, 1'b1);
      chk("coll_idx", {6'h0, scan_idx}, 8'h03);
      us_n(7);
      cyc(1'b0, 1'b0);
      chk("coll_blank_dig", {4'h0, dig_out}, 8'h0F);
      us_n(1);
      cyc(1'b0, 1'b0);
      chk("coll_show_dig", {4'h0, dig_out}, 8'h07);
      chk("coll_show_seg", seg_out, 8'hB0);
      us_n(3);
      sys_rst = 1'b1;
      @(negedge sys_clk_p);
      sys_rst = 1'b0;
      chk("rst_show_seg", seg_out, 8'hFF);
      chk("rst_show_dig", {4'h0, dig_out}, 8'h0F);
      chk("rst_show_idx", {6'h0, scan_idx}, 8'h00);
      us_n(12);
      repeat (3) cyc(1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
